// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the data-memory store buffer.
// The entry struct describes one buffered store at the default widths.
package riscv_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LREQ  = 2'd1,
    LWAIT = 2'd2,
    RESP  = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_entries.sv
// Store-buffer storage: circular FIFO of posted stores plus a combinational
// youngest-match lookup used to forward data to loads.
module sb_entries
  import riscv_mem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_no_overflow:  assert (!(push && full));
      a_no_underflow: assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the core data port and data memory: stores
// retire immediately, loads forward from the buffer or bypass pending drains.
module dmem_store_buffer
  import riscv_mem_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_wr,
  input  logic              core_rd,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  buf_count
);

  ld_state_e         state_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              sb_push;
  logic              sb_pop;
  logic              sb_hit;
  logic [DATA_W-1:0] sb_hit_data;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data;
  logic              sb_empty;
  logic              sb_full;

  logic              rd_miss_idle;
  logic              ld_req;
  logic              drain_vld;

  sb_entries #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_entries (
    .clk         (clk),
    .reset       (reset),
    .push        (sb_push),
    .push_addr   (core_addr),
    .push_data   (core_wr_data),
    .pop         (sb_pop),
    .lookup_addr (core_addr),
    .hit         (sb_hit),
    .hit_data    (sb_hit_data),
    .head_addr   (sb_head_addr),
    .head_data   (sb_head_data),
    .empty       (sb_empty),
    .full        (sb_full),
    .count       (buf_count)
  );

  // A simultaneous rd+wr is handled as a read, so the store is never posted.
  assign sb_push = core_wr && !core_rd && !sb_full;

  // A missing load claims the memory port in the same cycle it is detected,
  // so it overtakes every queued drain rather than waiting behind them.
  assign rd_miss_idle = (state_q == IDLE) && core_rd && !sb_hit;
  assign ld_req       = (state_q == LREQ);
  assign drain_vld    = !sb_empty && !rd_miss_idle &&
                        ((state_q == IDLE) || (state_q == RESP));
  assign sb_pop       = drain_vld && mem_req_ready;

  assign mem_req_valid = ld_req || drain_vld;
  assign mem_we        = drain_vld;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ld_req) begin
      mem_addr = core_addr;
    end else if (drain_vld) begin
      mem_addr  = sb_head_addr;
      mem_wdata = sb_head_data;
    end
  end

  assign core_stall = (core_wr && sb_full) || (core_rd && (state_q != RESP));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_rd) begin
            if (sb_hit) begin
              rd_data_q <= sb_hit_data;
              state_q   <= RESP;
            end else begin
              state_q <= LREQ;
            end
          end
        end
        LREQ: begin
          if (mem_req_ready) state_q <= LWAIT;
        end
        LWAIT: begin
          if (mem_rvalid) begin
            rd_data_q <= mem_rdata;
            state_q   <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_rd_data = rd_data_q;

  a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset)
    !(core_rd && core_wr));

  // An unaccepted request stays up with stable fields; the only exception is a
  // drain withdrawn because a load miss took the port.
  a_req_hold: assert property (@(posedge clk) disable iff (!reset)
    ($past(reset) && $past(mem_req_valid) && !$past(mem_req_ready) &&
     !($past(mem_we) && (ld_req || rd_miss_idle)))
    |-> (mem_req_valid && (mem_we == $past(mem_we)) &&
         (mem_addr == $past(mem_addr)) && (mem_wdata == $past(mem_wdata))));

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed scenarios plus a random load/store mix
// checked against a flat core-visible memory and a program-order store list.
module tb_dmem_store_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_wr;
  logic              core_rd;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_stall;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [CNT_W-1:0]  buf_count;

  always #5 clk = ~clk;

  dmem_store_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_wr       (core_wr),
    .core_rd       (core_rd),
    .core_addr     (core_addr),
    .core_wr_data  (core_wr_data),
    .core_rd_data  (core_rd_data),
    .core_stall    (core_stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .buf_count     (buf_count)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus-owned state
  int ready_mode  = 0;   // 0 low, 1 high, 2 random, 3 high from release_cyc on
  int release_cyc = 0;
  int rd_lat      = 1;
  int wr_chk      = 0;
  logic [DATA_W-1:0]        ref_mem [512];
  logic [ADDR_W+DATA_W-1:0] exp_wr_q [$];

  // Memory-side state
  int cyc       = 0;
  int rd_cnt    = 0;
  int rvld_cnt  = 0;
  int wr_at_rd  = 0;
  int rcnt      = 0;
  logic [ADDR_W-1:0]        last_rd_addr;
  logic [DATA_W-1:0]        rd_pend;
  logic [DATA_W-1:0]        phys_mem [512];
  bit                       written  [512];
  logic [ADDR_W+DATA_W-1:0] wr_log [$];

  function automatic logic [DATA_W-1:0] init_val(input int a);
    if (a == 'h030) return 32'h0000_DEAD;
    return 32'hC000_0000 | DATA_W'(a * 7 + 1);
  endfunction

  function automatic logic [DATA_W-1:0] phys_view(input int a);
    return written[a] ? phys_mem[a] : init_val(a);
  endfunction

  // Memory responder: decides ready and evaluates handshakes mid-cycle so the
  // next rising edge sees stable inputs.
  always @(negedge clk) begin
    cyc++;
    mem_rvalid = 1'b0;
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_pend;
        rvld_cnt++;
      end
    end
    case (ready_mode)
      0:       mem_req_ready = 1'b0;
      1:       mem_req_ready = 1'b1;
      2:       mem_req_ready = ($urandom_range(0, 9) < 6);
      default: mem_req_ready = (cyc >= release_cyc);
    endcase
    if (mem_req_valid && mem_req_ready) begin
      if (mem_we) begin
        wr_log.push_back({mem_addr, mem_wdata});
        phys_mem[mem_addr] = mem_wdata;
        written[mem_addr]  = 1'b1;
      end else begin
        rd_cnt++;
        wr_at_rd     = wr_log.size();
        last_rd_addr = mem_addr;
        rd_pend      = phys_view(int'(mem_addr));
        rcnt         = rd_lat;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          output int stalls);
    bit acc = 1'b0;
    stalls       = 0;
    core_wr      = 1'b1;
    core_addr    = a;
    core_wr_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!core_stall) begin
        acc = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    check("store_accept", 64'(acc), 64'(1));
    if (acc) begin
      ref_mem[a] = d;
      exp_wr_q.push_back({a, d});
    end
    step();
    core_wr = 1'b0;
  endtask

  task automatic do_load(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d,
                         output int stalls);
    bit done = 1'b0;
    stalls    = 0;
    d         = '0;
    core_rd   = 1'b1;
    core_addr = a;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!core_stall) begin
        d    = core_rd_data;
        done = 1'b1;
        break;
      end
      stalls++;
      step();
    end
    check("load_done", 64'(done), 64'(1));
    step();
    core_rd = 1'b0;
  endtask

  task automatic verify_drains(input bit complete);
    if (complete) check("drain_count", 64'(wr_log.size()), 64'(exp_wr_q.size()));
    for (int i = wr_chk; i < wr_log.size() && i < exp_wr_q.size(); i++)
      check("drain_order", 64'(wr_log[i]), 64'(exp_wr_q[i]));
    wr_chk = wr_log.size();
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (buf_count == '0) break;
    end
    check("drain_empty", 64'(buf_count), 64'(0));
    step();
    verify_drains(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish within its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int r0;
    int w0;
    int v0;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;

    reset        = 1'b0;
    core_wr      = 1'b0;
    core_rd      = 1'b0;
    core_addr    = '0;
    core_wr_data = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_buf_count", 64'(buf_count), 64'(0));
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rd_data", 64'(core_rd_data), 64'(0));
    check("rst_stall", 64'(core_stall), 64'(0));
    step();
    reset = 1'b1;
    step();

    // Single store then a forwarded load with drains blocked
    ready_mode = 0;
    do_store(9'h010, 32'h1AA, st);
    check("t1_store_stall", 64'(st), 64'(0));
    @(negedge clk);
    check("t1_buf_count", 64'(buf_count), 64'(1));
    step();
    r0 = rd_cnt;
    do_load(9'h010, d, st);
    check("t1_hit_stalls", 64'(st), 64'(1));
    check("t1_hit_data", 64'(d), 64'(32'h1AA));
    check("t1_no_mem_read", 64'(rd_cnt), 64'(r0));

    // Youngest matching entry wins
    do_store(9'h020, 32'h11, st);
    do_store(9'h020, 32'h22, st);
    do_load(9'h020, d, st);
    check("t2_youngest", 64'(d), 64'(32'h22));
    check("t2_buf_count", 64'(buf_count), 64'(3));
    ready_mode = 1;
    wait_drained();

    // Miss load overtakes queued drains
    ready_mode = 0;
    do_store(9'h040, 32'h41, st);
    do_store(9'h044, 32'h44, st);
    ready_mode = 1;
    rd_lat     = 2;
    w0 = wr_log.size();
    r0 = rd_cnt;
    do_load(9'h030, d, st);
    check("t3_miss_data", 64'(d), 64'(32'hDEAD));
    check("t3_min_stalls", 64'(st >= 3), 64'(1));
    check("t3_one_read", 64'(rd_cnt - r0), 64'(1));
    check("t3_read_addr", 64'(last_rd_addr), 64'(9'h030));
    check("t3_read_first", 64'(wr_at_rd), 64'(w0));
    wait_drained();

    // Fill to capacity; the fifth store stalls until a slot frees up
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      do_store(ADDR_W'(9'h100 + i), DATA_W'(32'h5000 + i), st);
      check("t4_store_stall", 64'(st), 64'(0));
    end
    @(negedge clk);
    check("t4_full_count", 64'(buf_count), 64'(4));
    step();
    release_cyc = cyc + 4;
    ready_mode  = 3;
    do_store(9'h104, 32'h5004, st);
    check("t4_full_stalls", 64'(st), 64'(4));
    ready_mode = 1;
    wait_drained();
    ready_mode = 0;
    for (int i = 5; i < 8; i++) do_store(ADDR_W'(9'h100 + i), DATA_W'(32'h5000 + i), st);
    do_load(9'h106, d, st);
    check("t4_wrap_hit", 64'(d), 64'(32'h5006));
    ready_mode = 1;
    rd_lat     = 1;
    do_load(9'h104, d, st);
    check("t4_wrap_load", 64'(d), 64'(32'h5004));
    wait_drained();

    // Reset during LWAIT with stores queued
    ready_mode = 0;
    for (int i = 0; i < 3; i++) do_store(ADDR_W'(9'h0C0 + i), DATA_W'(32'h7700 + i), st);
    r0 = rd_cnt;
    v0 = rvld_cnt;
    ready_mode = 1;
    rd_lat     = 6;
    core_rd    = 1'b1;
    core_addr  = 9'h1F0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rd_cnt > r0) break;
    end
    check("t5_read_issued", 64'(rd_cnt - r0), 64'(1));
    check("t5_pre_count", 64'(buf_count), 64'(3));
    ready_mode = 0;
    core_rd    = 1'b0;
    reset      = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check("t5_count_cleared", 64'(buf_count), 64'(0));
    check("t5_req_valid", 64'(mem_req_valid), 64'(0));
    check("t5_rd_data", 64'(core_rd_data), 64'(0));
    step();
    verify_drains(1'b0);
    while (exp_wr_q.size() > wr_log.size()) void'(exp_wr_q.pop_back());
    for (int i = 0; i < 512; i++) ref_mem[i] = phys_view(i);
    repeat (8) step();
    check("t5_late_rvalid_seen", 64'(rvld_cnt - v0), 64'(1));
    check("t5_rd_data_kept", 64'(core_rd_data), 64'(0));
    check("t5_count_after", 64'(buf_count), 64'(0));

    // Random mix against the reference memory
    ready_mode = 2;
    for (int n = 0; n < 250; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      a  = ADDR_W'(9'h180 + $urandom_range(0, 7));
      if (op < 5) begin
        do_store(a, DATA_W'($urandom), st);
      end else if (op < 9) begin
        rd_lat = int'($urandom_range(1, 3));
        do_load(a, d, st);
        check("rand_load", 64'(d), 64'(ref_mem[a]));
      end else begin
        step();
      end
    end
    ready_mode = 1;
    wait_drained();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
